cpu_mem_arbiter: RTL and testbench

- Shares the CPU's single-port synchronous memory between two requesters: the instruction-fetch unit (read only) and the load/store data path (read/write).
- Arbitrates round-robin, sequences the memory's cs/we/addr/wdata, and returns read data with a one-cycle ack per transaction.
- Sits between the CPU core (program counter and register file) and the memory block.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/rr_arb2.sv | 16 +
 rtl/cpu_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encoding, port ids and default widths for the CPU memory arbiter
package cpu_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA = 1'b1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; bit 1 is the data port, bit 0 the fetch port
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       pointer,
  output logic       grant_valid,
  output logic       grant_id
);
  logic [1:0] live;
  // masked requests; on a tie the pointer names the winner
  always_comb begin
    live = req & ~mask;
    grant_valid = |live;
    grant_id = (&live) ? pointer : live[1];
  end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: round-robin sharing of a single-port synchronous memory between fetch and load/store
module cpu_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  state_t state_q, state_d;
  logic ptr_q, ptr_d;
  logic owner_q, owner_d;
  logic we_q, we_d;
  logic mem_cs_q, mem_cs_d;
  logic mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic f_ack_q, f_ack_d;
  logic d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [1:0] mask;
  logic grant_valid, grant_id;
  logic in_resp, rd_fetch, rd_data;

  // the owner is masked during its response cycle because its req is still high while it sees ack
  always_comb begin
    in_resp = state_q == RESP;
    mask = {in_resp & owner_q, in_resp & ~owner_q};
    rd_fetch = in_resp & (owner_q == PORT_FETCH);
    rd_data = in_resp & (owner_q == PORT_DATA) & ~we_q;
  end

  rr_arb2 u_arb (
    .req        ({d_req, f_req}),
    .mask       (mask),
    .pointer    (ptr_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  // next state: grant from IDLE or RESP, access for one cycle, acknowledge in RESP
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    we_d = we_q;
    mem_cs_d = 1'b0;
    mem_we_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_ack_d = 1'b0;
    d_ack_d = 1'b0;
    f_rdata_d = rd_fetch ? mem_rdata : f_rdata_q;
    d_rdata_d = rd_data ? mem_rdata : d_rdata_q;
    if (state_q == ACCESS) begin
      state_d = RESP;
      f_ack_d = owner_q == PORT_FETCH;
      d_ack_d = owner_q == PORT_DATA;
    end else if (grant_valid) begin
      state_d = ACCESS;
      owner_d = grant_id;
      ptr_d = ~grant_id;
      we_d = grant_id & d_we;
      mem_cs_d = 1'b1;
      mem_we_d = grant_id & d_we;
      mem_addr_d = grant_id ? d_addr : f_addr;
      mem_wdata_d = grant_id ? d_wdata : mem_wdata_q;
    end else begin
      state_d = IDLE;
    end
  end

  // state and output registers; reset abandons any access in flight and gives data the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= PORT_DATA;
      owner_q <= PORT_FETCH;
      we_q <= 1'b0;
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      f_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      we_q <= we_d;
      mem_cs_q <= mem_cs_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_ack_q <= f_ack_d;
      d_ack_q <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // read data is forwarded from memory during the response cycle so it is valid alongside the ack
  assign f_rdata = rd_fetch ? mem_rdata : f_rdata_q;
  assign d_rdata = rd_data ? mem_rdata : d_rdata_q;
  assign f_ack = f_ack_q;
  assign d_ack = d_ack_q;
  assign mem_cs = mem_cs_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed table, corner sequences and randomized traffic against a transaction-level model
module tb_cpu_mem_arbiter;
  logic clk, reset;
  logic f_req, f_ack, d_req, d_we, d_ack, mem_cs, mem_we, busy;
  logic [7:0] f_addr, f_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic init_mem;
  logic [7:0] exp_f, exp_d;
  int errors, checks;

  typedef struct {
    logic port;
    logic we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;
  vec_t vt[8];

  cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h0A;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_cs && !mem_we) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input string nm);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    @(negedge clk);
    chk({nm, "_access"}, {mem_cs, mem_we, busy, f_ack, d_ack, mem_addr}, {1'b1, v.we, 1'b1, 1'b0, 1'b0, v.addr});
    if (v.we) chk({nm, "_wdata"}, mem_wdata, v.wdata);
    @(negedge clk);
    chk({nm, "_resp"}, {f_ack, d_ack, mem_cs, mem_we, busy}, {!v.port, v.port, 1'b0, 1'b0, 1'b1});
    if (v.port) begin
      d_req = 1'b0;
      if (v.we) ref_mem[v.addr] = v.wdata;
      else exp_d = v.rdata;
    end else begin
      f_req = 1'b0;
      exp_f = v.rdata;
    end
    chk({nm, "_rdata"}, {f_rdata, d_rdata}, {exp_f, exp_d});
    @(negedge clk);
    chk({nm, "_after"}, {f_ack, d_ack, busy, mem_cs}, 4'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_f = 8'h00;
    exp_d = 8'h00;
  endtask

  initial begin
    int n, last, cyc, fr, dr;
    logic fp, dp, dwe;
    logic [7:0] fa, da, dw;
    vec_t v;
    errors = 0; checks = 0;
    init_mem = 1'b1; reset = 1'b0;
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    exp_f = 0; exp_d = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h0A;
    vt[0] = '{1'b0, 1'b0, 8'h04, 8'h00, 8'h0E};
    vt[1] = '{1'b1, 1'b1, 8'h06, 8'h0A, 8'h00};
    vt[2] = '{1'b1, 1'b0, 8'h06, 8'h00, 8'h0A};
    vt[3] = '{1'b0, 1'b0, 8'h06, 8'h00, 8'h0A};
    vt[4] = '{1'b1, 1'b1, 8'hFF, 8'hA5, 8'h00};
    vt[5] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'hA5};
    vt[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h0A};
    vt[7] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h8A};

    repeat (5) @(negedge clk);
    init_mem = 1'b0;
    chk("reset_outputs", {f_ack, d_ack, mem_cs, mem_we, busy, f_rdata, d_rdata, mem_addr, mem_wdata}, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_outputs", {f_ack, d_ack, mem_cs, mem_we, busy, f_rdata, d_rdata, mem_addr, mem_wdata}, 0);
    end

    for (int i = 0; i < 8; i++) do_txn(vt[i], $sformatf("vec%0d", i));

    pulse_reset();
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 8'h77;
    f_req = 1; f_addr = 8'h04;
    @(negedge clk);
    chk("tie_data_first", {mem_cs, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'h10, 8'h77});
    @(negedge clk);
    chk("tie_d_ack", {d_ack, f_ack}, 2'b10);
    d_req = 0;
    ref_mem[8'h10] = 8'h77;
    @(negedge clk);
    chk("tie_fetch_b2b", {mem_cs, mem_we, busy, mem_addr}, {1'b1, 1'b0, 1'b1, 8'h04});
    @(negedge clk);
    chk("tie_f_ack", {f_ack, d_ack, f_rdata}, {1'b1, 1'b0, 8'h0E});
    f_req = 0;
    exp_f = 8'h0E;
    @(negedge clk);
    chk("tie_idle", busy, 0);

    d_req = 1; d_we = 0; d_addr = 8'h10; f_req = 1; f_addr = 8'h04;
    n = 0; last = 0;
    for (int c = 1; c <= 40 && n < 8; c++) begin
      @(negedge clk);
      chk("fair_one_ack", f_ack & d_ack, 0);
      if (f_ack || d_ack) begin
        chk($sformatf("fair_order%0d", n), d_ack, (n % 2) == 0);
        chk($sformatf("fair_gap%0d", n), c - last, 2);
        if (d_ack) chk("fair_d_rdata", d_rdata, 8'h77);
        else chk("fair_f_rdata", f_rdata, 8'h0E);
        last = c;
        n++;
        if (n == 8) begin
          d_req = 0; f_req = 0;
        end
      end
    end
    chk("fair_count", n, 8);
    d_req = 0; f_req = 0;
    exp_d = 8'h77;
    @(negedge clk);
    chk("fair_idle", busy, 0);

    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h99;
    @(negedge clk);
    chk("midrst_access", {mem_cs, mem_we}, 2'b11);
    #1 reset = 1'b0;
    #1 chk("midrst_drop", {mem_cs, mem_we, busy, d_ack}, 0);
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_ack", d_ack, 0);
    end
    reset = 1'b1;
    exp_f = 8'h00; exp_d = 8'h00;
    v = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h2A};
    do_txn(v, "post_rst_load");
    v = '{1'b1, 1'b1, 8'h20, 8'h99, 8'h00};
    do_txn(v, "post_rst_store");
    v = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h99};
    do_txn(v, "post_rst_reload");

    fp = 0; dp = 0; fr = 0; dr = 0; cyc = 0; dwe = 0; fa = 0; da = 0; dw = 0;
    while (cyc < 600 || fp || dp) begin
      @(negedge clk);
      cyc++;
      if (mem_we) chk("rnd_we_needs_cs", mem_cs, 1);
      if (f_ack) begin
        chk("rnd_f_expected", fp, 1);
        chk("rnd_f_latency_ok", (cyc - fr >= 2) && (cyc - fr <= 4), 1);
        exp_f = ref_mem[fa];
        chk("rnd_f_rdata", f_rdata, exp_f);
        fp = 0; f_req = 0;
      end else begin
        chk("rnd_f_hold", f_rdata, exp_f);
        if (fp && cyc - fr > 4) begin
          chk("rnd_f_timeout", cyc - fr, 4);
          fp = 0; f_req = 0;
        end else if (!fp && cyc < 600 && $urandom_range(0, 2) == 0) begin
          fa = 8'($urandom_range(0, 15));
          f_addr = fa; f_req = 1; fp = 1; fr = cyc;
        end
      end
      if (d_ack) begin
        chk("rnd_d_expected", dp, 1);
        chk("rnd_d_latency_ok", (cyc - dr >= 2) && (cyc - dr <= 4), 1);
        if (dwe) ref_mem[da] = dw;
        else exp_d = ref_mem[da];
        chk("rnd_d_rdata", d_rdata, exp_d);
        dp = 0; d_req = 0;
      end else begin
        chk("rnd_d_hold", d_rdata, exp_d);
        if (dp && cyc - dr > 4) begin
          chk("rnd_d_timeout", cyc - dr, 4);
          dp = 0; d_req = 0;
        end else if (!dp && cyc < 600 && $urandom_range(0, 2) == 0) begin
          da = 8'($urandom_range(0, 15));
          dw = 8'($urandom);
          dwe = 1'($urandom_range(0, 1));
          d_addr = da; d_wdata = dw; d_we = dwe; d_req = 1; dp = 1; dr = cyc;
        end
      end
    end
    @(negedge clk);
    chk("end_idle", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
